// File: rtl/adder_link_host.sv
// adder_link_host
// Host-side link for a bit-serial adder. Takes a parallel add request,
// streams the operands out LSB-first over a valid/ready handshake,
// collects the serial sum bits back LSB-first, and presents the assembled
// parallel sum until the consumer takes it. One transaction at a time.

module adder_link_host #(
  parameter int DATA_WIDTH = 16  // operand and sum width; must be >= 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  // parallel request side
  input  logic [DATA_WIDTH-1:0] iv_a,
  input  logic [DATA_WIDTH-1:0] iv_b,
  input  logic                  i_cin,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  // serial operand stream to the adder
  output logic                  o_din_a,
  output logic                  o_din_b,
  output logic                  o_cin,
  output logic                  o_valid,
  input  logic                  i_dut_ready,
  // serial sum stream from the adder
  input  logic                  i_sum,
  input  logic                  i_sum_valid,
  output logic                  o_sum_ready,
  // parallel result side
  output logic [DATA_WIDTH-1:0] ov_sum,
  output logic                  o_sum_valid,
  input  logic                  i_sum_ready,
  // status
  output logic                  o_protocol_err
);

  // Wide enough to hold the value DATA_WIDTH itself, so the terminal
  // count is an exact compare rather than a wrap to zero.
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT_OUT = 2'd1,
    SHIFT_IN  = 2'd2,
    HOLD      = 2'd3
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_a_sh;
  logic [DATA_WIDTH-1:0] r_b_sh;
  logic                  r_cin;
  logic [CNT_W-1:0]      r_cnt;
  // Holds the sum bits received so far, top-aligned. It is one bit
  // narrower than the sum: the last bit goes straight into r_sum_out.
  logic [DATA_WIDTH-2:0] r_sum_part;
  logic [DATA_WIDTH-1:0] r_sum_out;
  logic                  r_req_ready;
  logic                  r_valid;
  logic                  r_sum_ready;
  logic                  r_sum_valid;
  logic                  r_protocol_err;

  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  w_cnt_done;
  logic [DATA_WIDTH-1:0] w_sum_full;

  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_cnt_done = (w_cnt_inc == CNT_LAST);
  // New bit enters at the MSB; everything already received moves down one.
  assign w_sum_full = {i_sum, r_sum_part};

  // Control FSM plus all datapath registers; i_rst wins over i_en, and
  // i_en low leaves every register untouched.
  // NOTE: every register here uses <= so all of them sample the same
  // pre-edge values; a blocking = would let later statements see
  // half-updated state and change behavior with statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= IDLE;
      r_a_sh         <= '0;
      r_b_sh         <= '0;
      r_cin          <= 1'b0;
      r_cnt          <= '0;
      r_sum_part     <= '0;
      r_sum_out      <= '0;
      r_req_ready    <= 1'b1;
      r_valid        <= 1'b0;
      r_sum_ready    <= 1'b0;
      r_sum_valid    <= 1'b0;
      r_protocol_err <= 1'b0;
    end else if (i_en) begin
      // A sum bit offered while we are not collecting is dropped and flagged.
      if (i_sum_valid && (r_state != SHIFT_IN)) begin
        r_protocol_err <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_a_sh      <= iv_a;
            r_b_sh      <= iv_b;
            r_cin       <= i_cin;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_valid     <= 1'b1;
            r_state     <= SHIFT_OUT;
          end
        end

        SHIFT_OUT: begin
          // r_valid is high throughout this state, so i_dut_ready alone
          // completes the handshake.
          if (i_dut_ready) begin
            r_a_sh <= r_a_sh >> 1;
            r_b_sh <= r_b_sh >> 1;
            if (w_cnt_done) begin
              r_cnt       <= '0;
              r_valid     <= 1'b0;
              r_sum_ready <= 1'b1;
              r_state     <= SHIFT_IN;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end

        SHIFT_IN: begin
          if (i_sum_valid) begin
            r_sum_part <= w_sum_full[DATA_WIDTH-1:1];
            if (w_cnt_done) begin
              r_cnt       <= '0;
              r_sum_out   <= w_sum_full;
              r_sum_ready <= 1'b0;
              r_sum_valid <= 1'b1;
              r_state     <= HOLD;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end

        HOLD: begin
          if (i_sum_ready) begin
            r_sum_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Handshake strobes are registered but masked by i_en so a frozen link
  // never offers or accepts anything; result-side outputs just hold.
  assign o_req_ready    = r_req_ready & i_en;
  assign o_valid        = r_valid & i_en;
  assign o_sum_ready    = r_sum_ready & i_en;
  assign o_din_a        = r_a_sh[0];
  assign o_din_b        = r_b_sh[0];
  assign o_cin          = r_cin & ((r_state == SHIFT_OUT) || (r_state == SHIFT_IN));
  assign ov_sum         = r_sum_out;
  assign o_sum_valid    = r_sum_valid;
  assign o_protocol_err = r_protocol_err;

endmodule

// File: doc/adder_link_host.md
ADDER_LINK_HOST -- requirements
Module: adder_link_host

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, default 16, operand and sum width in bits.
REQ-002 SHALL have port: i_clk  input  1  the single clock; all logic on the rising edge.
REQ-003 SHALL have port: i_rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: i_en  input  1  global enable; low freezes all state.
REQ-005 SHALL have port: iv_a  input  DATA_WIDTH  request operand A.
REQ-006 SHALL have port: iv_b  input  DATA_WIDTH  request operand B.
REQ-007 SHALL have port: i_cin  input  1  request carry-in.
REQ-008 SHALL have port: i_req_valid  input  1  request valid.
REQ-009 SHALL have port: o_req_ready  output  1  request ready.
REQ-010 SHALL have port: o_din_a  output  1  serial operand A bit to the adder.
REQ-011 SHALL have port: o_din_b  output  1  serial operand B bit to the adder.
REQ-012 SHALL have port: o_cin  output  1  latched carry-in to the adder.
REQ-013 SHALL have port: o_valid  output  1  serial operand bit valid.
REQ-014 SHALL have port: i_dut_ready  input  1  adder ready for operand bits.
REQ-015 SHALL have port: i_sum  input  1  serial sum bit from the adder.
REQ-016 SHALL have port: i_sum_valid  input  1  serial sum bit valid.
REQ-017 SHALL have port: o_sum_ready  output  1  ready for sum bits (drives the adder's i_ready).
REQ-018 SHALL have port: ov_sum  output  DATA_WIDTH  assembled parallel sum.
REQ-019 SHALL have port: o_sum_valid  output  1  parallel sum valid.
REQ-020 SHALL have port: i_sum_ready  input  1  consumer ready for the parallel sum.
REQ-021 SHALL have port: o_protocol_err  output  1  sticky protocol-error flag.

Function
REQ-022 SHALL implement FSM states IDLE, SHIFT_OUT, SHIFT_IN, HOLD; only one transaction outstanding at a time.
REQ-023 IDLE: o_req_ready=1; on i_req_valid, SHALL latch iv_a, iv_b and i_cin, clear the bit counter, and go to SHIFT_OUT next cycle.
REQ-024 SHIFT_OUT: o_valid=1; o_din_a and o_din_b SHALL present the current LSB of the A and B shift registers.
REQ-025 An operand bit SHALL transfer on an edge where o_valid and i_dut_ready are both high; on transfer, the shift registers shift right one place and the counter increments.
REQ-026 Without a transfer, o_din_a, o_din_b and o_valid SHALL hold unchanged.
REQ-027 After the DATA_WIDTH-th operand transfer, the FSM SHALL go to SHIFT_IN and clear the counter; o_valid drops in the same cycle the state changes.
REQ-028 o_cin SHALL equal the latched carry-in in SHIFT_OUT and SHIFT_IN, and 0 otherwise.
REQ-029 SHIFT_IN: o_sum_ready=1; a sum bit SHALL be accepted on an edge where i_sum_valid and o_sum_ready are both high.
REQ-030 Sum bits arrive LSB-first; each accepted bit SHALL enter the sum register at the MSB with a right shift, so after DATA_WIDTH bits the first-received bit sits at bit 0.
REQ-031 After the DATA_WIDTH-th accepted sum bit, the FSM SHALL go to HOLD.
REQ-032 HOLD: o_sum_valid=1 and ov_sum stable; on i_sum_ready, the FSM SHALL return to IDLE next cycle, with o_sum_valid=0 from that cycle.
REQ-033 ov_sum SHALL hold its last value outside HOLD.
REQ-034 Latency SHALL be 1 request cycle + DATA_WIDTH operand transfers + DATA_WIDTH sum transfers + 1 cycle into HOLD.
REQ-035 i_sum_valid high outside SHIFT_IN SHALL be ignored (no data change) and SHALL set o_protocol_err, which stays set until reset.
REQ-036 The bit counter SHALL be ceil(log2(DATA_WIDTH+1)) bits wide and compare against DATA_WIDTH exactly; no wrap-around.
REQ-037 i_en low SHALL freeze state, counter and registers, and force o_req_ready, o_valid and o_sum_ready to 0; o_sum_valid and ov_sum hold.
REQ-038 i_rst takes priority over i_en.

Reset
REQ-039 On i_rst high at an edge, the block SHALL enter IDLE; all shift registers, the counter, ov_sum and o_protocol_err go to 0; o_valid, o_sum_ready and o_sum_valid go to 0; o_req_ready goes to 1 on the following cycle when i_en=1.
REQ-040 Reset mid-transaction SHALL abandon the transaction with no partial output.

Verification
REQ-041 Basic add: a=0x0003, b=0x0005, cin=0, i_dut_ready=1 -> o_din_a sequence 1,1,0x14 and o_din_b sequence 1,0,1,0x13; feeding sum bits of 0x0008 -> ov_sum=0x0008 with o_sum_valid.
REQ-042 Operand backpressure: i_dut_ready toggles 1,0,0,1 pattern, a=0xA5C3 -> exactly 16 transfers, in order, no duplicates or drops; o_din_a is stable while stalled.
REQ-043 Result backpressure: i_sum_ready=0 for 10 cycles in HOLD, ov_sum=0xFFFF -> ov_sum stays 0xFFFF and o_req_ready=0 throughout; i_sum_ready=1 -> IDLE next cycle.
REQ-044 Reset after 5 operand transfers -> next cycle o_valid=0 and ov_sum=0; a new request a=0x0001 then serializes from bit 0.
REQ-045 i_en=0 for 4 cycles mid-SHIFT_IN -> no sum bits accepted and o_sum_ready=0; resuming yields the correct full sum.
REQ-046 i_sum_valid=1 in IDLE -> o_protocol_err=1 from the next cycle and stays 1 until i_rst.
